// File: rtl/pulse_generator_if.sv
// ============================================================================
// Module  : pulse_generator_if
// Brief   : Trigger/operand/waveform bundle between a strobe source and
//           pulse_generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_generator_if #(
    parameter int CNT_W = 8
);
    logic             trig_i;
    logic [CNT_W-1:0] width_i;
    logic [CNT_W-1:0] gap_i;
    logic [CNT_W-1:0] count_i;
    logic             pulse_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output trig_i, width_i, gap_i, count_i,
        input  pulse_o, busy_o, done_o
    );

    modport slave (
        input  trig_i, width_i, gap_i, count_i,
        output pulse_o, busy_o, done_o
    );
endinterface

`default_nettype wire

// File: rtl/pulse_generator.sv
// ============================================================================
// Module  : pulse_generator
// Brief   : Expands a single-cycle strobe into a burst of count pulses, each
//           width cycles high followed by a gap-cycle low interval.
//           Optional macro PULSE_GEN_RETRIG_EN: a trigger while busy restarts
//           the burst instead of being dropped.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_generator #(
    parameter int CNT_W    = 8,
    parameter bit IDLE_LVL = 1'b0
) (
    input  wire              clk_i,
    input  wire              rst_i,
    pulse_generator_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] w_width_clamped;
    logic [CNT_W-1:0] w_count_clamped;
    logic             w_retrig;
    logic             w_launch;

    assign w_width_clamped = (bus.width_i == '0) ? c_ONE : bus.width_i;
    assign w_count_clamped = (bus.count_i == '0) ? c_ONE : bus.count_i;

`ifdef PULSE_GEN_RETRIG_EN
    assign w_retrig = bus.trig_i && (state_q != ST_IDLE);
`else
    assign w_retrig = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
            pcnt_q  <= '0;
            width_q <= '0;
            gap_q   <= '0;
            pulse_q <= IDLE_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            pcnt_q  <= pcnt_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        gcnt_d   = gcnt_q;
        pcnt_d   = pcnt_q;
        width_d  = width_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        w_launch = w_retrig;

        case (state_q)
            ST_IDLE: begin
                if (bus.trig_i) begin
                    w_launch = 1'b1;
                end
            end
            ST_HIGH: begin
                if (wcnt_q == c_ONE) begin
                    if (pcnt_q == c_ONE) begin
                        // Burst ends here; a trigger on this same edge chains
                        // straight into a new burst without an idle cycle.
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        if (bus.trig_i) begin
                            w_launch = 1'b1;
                        end
                    end else if (gap_q != '0) begin
                        state_d = ST_LOW;
                        gcnt_d  = gap_q;
                    end else begin
                        wcnt_d = width_q;
                        pcnt_d = pcnt_q - c_ONE;
                    end
                end else begin
                    wcnt_d = wcnt_q - c_ONE;
                end
            end
            ST_LOW: begin
                if (gcnt_q == c_ONE) begin
                    state_d = ST_HIGH;
                    wcnt_d  = width_q;
                    pcnt_d  = pcnt_q - c_ONE;
                end else begin
                    gcnt_d = gcnt_q - c_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_launch) begin
            state_d = ST_HIGH;
            width_d = w_width_clamped;
            gap_d   = bus.gap_i;
            wcnt_d  = w_width_clamped;
            pcnt_d  = w_count_clamped;
            gcnt_d  = '0;
        end

        // Outputs are registered from the next state so launch latency is zero.
        pulse_d = (state_d == ST_HIGH) ? ~IDLE_LVL : IDLE_LVL;
        busy_d  = (state_d != ST_IDLE);
    end

    assign bus.pulse_o = pulse_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_generator.sv
// ============================================================================
// Module  : tb_pulse_generator
// Brief   : Directed-vector bench for pulse_generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_generator;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [31:0] p_v, b_v, d_v;

    pulse_generator_if #(.CNT_W(8)) bus ();

    pulse_generator #(
        .CNT_W    (8),
        .IDLE_LVL (1'b0)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input logic [7:0] w, input logic [7:0] g, input logic [7:0] c);
        bus.width_i = w;
        bus.gap_i   = g;
        bus.count_i = c;
    endtask

    // Bit i of each result holds the output sampled just after edge i;
    // trig_vec[i] is presented to edge i.
    task automatic run(input int n, input logic [31:0] trig_vec,
                       output logic [31:0] p, output logic [31:0] b, output logic [31:0] d);
        p = '0;
        b = '0;
        d = '0;
        for (int i = 0; i < n; i++) begin
            bus.trig_i = trig_vec[i];
            @(posedge clk);
            #1;
            p[i] = bus.pulse_o;
            b[i] = bus.busy_o;
            d[i] = bus.done_o;
        end
        bus.trig_i = 1'b0;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        bus.trig_i = 1'b0;
        set_ops(8'd0, 8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pulse", {31'd0, bus.pulse_o}, 32'd0);
        check_val("rst_busy",  {31'd0, bus.busy_o},  32'd0);
        check_val("rst_done",  {31'd0, bus.done_o},  32'd0);
        rst = 1'b0;

        // w=3 g=2 c=2, trigger at edge 5
        set_ops(8'd3, 8'd2, 8'd2);
        run(16, 32'h0000_0020, p_v, b_v, d_v);
        check_val("basic_pulse", p_v, 32'h0000_1CE0);
        check_val("basic_busy",  b_v, 32'h0000_1FE0);
        check_val("basic_done",  d_v, 32'h0000_2000);

        // zero width/count clamp to 1
        set_ops(8'd0, 8'd4, 8'd0);
        run(8, 32'h0000_0001, p_v, b_v, d_v);
        check_val("clamp_pulse", p_v, 32'h0000_0001);
        check_val("clamp_busy",  b_v, 32'h0000_0001);
        check_val("clamp_done",  d_v, 32'h0000_0002);

        // gap=0 merges pulses
        set_ops(8'd2, 8'd0, 8'd3);
        run(10, 32'h0000_0001, p_v, b_v, d_v);
        check_val("merge_pulse", p_v, 32'h0000_003F);
        check_val("merge_busy",  b_v, 32'h0000_003F);
        check_val("merge_done",  d_v, 32'h0000_0040);

        // second trigger two cycles into a 5-cycle pulse
        set_ops(8'd5, 8'd0, 8'd1);
        run(12, 32'h0000_0005, p_v, b_v, d_v);
`ifdef PULSE_GEN_RETRIG_EN
        check_val("retrig_pulse", p_v, 32'h0000_007F);
        check_val("retrig_busy",  b_v, 32'h0000_007F);
        check_val("retrig_done",  d_v, 32'h0000_0080);
`else
        check_val("retrig_pulse", p_v, 32'h0000_001F);
        check_val("retrig_busy",  b_v, 32'h0000_001F);
        check_val("retrig_done",  d_v, 32'h0000_0020);
`endif

        // reset during LOW phase: high 0..2, low from edge 3
        set_ops(8'd3, 8'd4, 8'd2);
        run(4, 32'h0000_0001, p_v, b_v, d_v);
        check_val("low_busy", {31'd0, bus.busy_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("abort_pulse", {31'd0, bus.pulse_o}, 32'd0);
        check_val("abort_busy",  {31'd0, bus.busy_o},  32'd0);
        check_val("abort_done",  {31'd0, bus.done_o},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(12, 32'h0000_0000, p_v, b_v, d_v);
        check_val("post_abort_busy", b_v, 32'h0000_0000);
        check_val("post_abort_done", d_v, 32'h0000_0000);

        set_ops(8'd3, 8'd2, 8'd2);
        run(12, 32'h0000_0001, p_v, b_v, d_v);
        check_val("rerun_pulse", p_v, 32'h0000_00E7);
        check_val("rerun_busy",  b_v, 32'h0000_00FF);
        check_val("rerun_done",  d_v, 32'h0000_0100);

        // trigger coincident with done chains bursts with no idle cycle
        set_ops(8'd2, 8'd1, 8'd1);
        run(8, 32'h0000_0005, p_v, b_v, d_v);
        check_val("b2b_pulse", p_v, 32'h0000_000F);
        check_val("b2b_busy",  b_v, 32'h0000_000F);
        check_val("b2b_done",  d_v, 32'h0000_0014);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
